maple_packet_parser: RTL and testbench

Byte-to-packet stage of the Maple bus receive path. Consumes the `frame`/`data_ready`/`data` byte stream produced by the Maple receiver front end and decodes the 4-byte header (length, sender, recipient, command). It packs the payload into 32-bit words, buffers them in a small FIFO for the host side, and reports per-packet completion and error status.

---
 rtl/maple_packet_parser_pkg.sv | 36 +++
 rtl/maple_packet_parser_if.sv | 28 ++
 rtl/maple_packet_parser_fifo.sv | 57 +++++
 rtl/maple_packet_parser.sv | 167 ++++++++++++++++
 tb/tb_maple_packet_parser.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/maple_packet_parser_pkg.sv
// Shared types and constants for the Maple packet parser.
// Enable the trailing CRC byte check with MAPLE_PKT_CRC_EN.
package maple_pkg;

    localparam int MAPLE_HDR_BYTES = 4;

    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_CRC   = 2;
    localparam int ERR_OVF   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
`ifdef MAPLE_PKT_CRC_EN
        ST_CRC,
`endif
        ST_TAIL
    } state_e;

    // State entered once the last payload word (or an empty payload) is consumed.
`ifdef MAPLE_PKT_CRC_EN
    localparam state_e ST_AFTER_PAYLOAD = ST_CRC;
`else
    localparam state_e ST_AFTER_PAYLOAD = ST_TAIL;
`endif

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] dst;
        logic [7:0] src;
        logic [7:0] len;
    } maple_hdr_t;

endpackage

// File: rtl/maple_packet_parser_if.sv
// Byte stream in, header/word/status out for the Maple packet parser.
interface maple_pkt_if;
    logic        frame;
    logic        data_ready;
    logic [7:0]  data;
    logic        hdr_valid;
    logic [7:0]  hdr_cmd;
    logic [7:0]  hdr_dst;
    logic [7:0]  hdr_src;
    logic [7:0]  hdr_len;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        pkt_done;
    logic [3:0]  pkt_error;

    modport slave (
        input  frame, data_ready, data, word_ready,
        output hdr_valid, hdr_cmd, hdr_dst, hdr_src, hdr_len,
        output word_valid, word_data, pkt_done, pkt_error
    );

    modport master (
        output frame, data_ready, data, word_ready,
        input  hdr_valid, hdr_cmd, hdr_dst, hdr_src, hdr_len,
        input  word_valid, word_data, pkt_done, pkt_error
    );
endinterface

// File: rtl/maple_packet_parser_fifo.sv
// Synchronous 32-bit word FIFO; head word is held in an output register
// that is loaded directly on a push into an (effectively) empty FIFO.
module maple_word_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [31:0] wr_data_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output logic [31:0] rd_data_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rd_data_q;
    logic          push_ok, pop_ok, head_bypass;

    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CW'(FIFO_DEPTH));
    assign pop_ok      = pop_i & ~empty_o;
    assign push_ok     = push_i & (~full_o | pop_ok);
    // The new word becomes the head when nothing else remains after this cycle's pop.
    assign head_bypass = push_ok & ((cnt_q == '0) | ((cnt_q == CW'(1)) & pop_ok));
    assign rd_ptr_nxt  = rd_ptr_q + AW'(1);
    assign cnt_d       = cnt_q + CW'(push_ok) - CW'(pop_ok);
    assign rd_data_o   = rd_data_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
            cnt_q    <= cnt_d;
            if (head_bypass) begin
                rd_data_q <= wr_data_i;
            end else if (pop_ok) begin
                rd_data_q <= mem_q[rd_ptr_nxt];
            end
        end
    end
endmodule

// File: rtl/maple_packet_parser.sv
// Maple receive byte-to-packet stage: header decode, payload word packing, status.
// Define MAPLE_PKT_CRC_EN to expect and check a trailing XOR CRC byte.
module maple_packet_parser
    import maple_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input logic        clk,
    input logic        reset,
    maple_pkt_if.slave bus
);
    localparam logic [1:0] GRP_LAST = 2'(MAPLE_HDR_BYTES - 1);

    state_e      state_q, state_d;
    logic        frame_q;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic        push_q, push_d;
    logic [3:0]  err_q, err_d, err_set;
    maple_hdr_t  hdr_q, hdr_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic        pkt_done_q, pkt_done_d;
`ifdef MAPLE_PKT_CRC_EN
    logic [7:0]  xor_q, xor_d;
`endif
    logic        byte_v, frame_rise, frame_end, last_byte;
    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_rd_data;

    assign byte_v     = bus.frame & bus.data_ready;
    assign frame_rise = bus.frame & ~frame_q;
    assign frame_end  = (state_q != ST_IDLE) & ~bus.frame;
    assign last_byte  = byte_v & (byte_cnt_q == GRP_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            frame_q     <= 1'b0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            asm_q       <= '0;
            push_q      <= 1'b0;
            err_q       <= '0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
`ifdef MAPLE_PKT_CRC_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            frame_q     <= bus.frame;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            asm_q       <= asm_d;
            push_q      <= push_d;
            err_q       <= err_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            pkt_done_q  <= pkt_done_d;
`ifdef MAPLE_PKT_CRC_EN
            xor_q       <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (frame_rise) state_d = ST_HEADER;
        end else if (frame_end) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_HEADER: begin
                    if (last_byte) state_d = (asm_q[15:8] == 8'd0) ? ST_AFTER_PAYLOAD : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (last_byte && word_cnt_q == 8'd1) state_d = ST_AFTER_PAYLOAD;
                end
`ifdef MAPLE_PKT_CRC_EN
                ST_CRC: begin
                    if (byte_v) state_d = ST_TAIL;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        asm_d       = asm_q;
        hdr_d       = hdr_q;
        hdr_valid_d = 1'b0;
        pkt_done_d  = 1'b0;
        push_d      = 1'b0;
        err_set     = '0;
`ifdef MAPLE_PKT_CRC_EN
        xor_d       = xor_q;
`endif
        // A pop in the same cycle frees the slot, so only an unpopped full FIFO drops.
        err_set[ERR_OVF] = push_q & fifo_full & ~bus.word_ready;
        if (state_q == ST_IDLE) begin
            byte_cnt_d = '0;
`ifdef MAPLE_PKT_CRC_EN
            xor_d      = '0;
`endif
        end else if (frame_end) begin
            pkt_done_d         = 1'b1;
            err_set[ERR_SHORT] = (state_q != ST_TAIL);
        end else if (byte_v) begin
            case (state_q)
                ST_HEADER, ST_PAYLOAD: begin
                    asm_d      = {bus.data, asm_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef MAPLE_PKT_CRC_EN
                    xor_d      = xor_q ^ bus.data;
`endif
                    if (last_byte && state_q == ST_HEADER) begin
                        hdr_d.cmd   = bus.data;
                        hdr_d.dst   = asm_q[31:24];
                        hdr_d.src   = asm_q[23:16];
                        hdr_d.len   = asm_q[15:8];
                        hdr_valid_d = 1'b1;
                        word_cnt_d  = asm_q[15:8];
                    end
                    if (last_byte && state_q == ST_PAYLOAD) begin
                        push_d     = 1'b1;
                        word_cnt_d = word_cnt_q - 8'd1;
                    end
                end
`ifdef MAPLE_PKT_CRC_EN
                ST_CRC:  err_set[ERR_CRC] = (bus.data != xor_q);
`endif
                ST_TAIL: err_set[ERR_LONG] = 1'b1;
                default: ;
            endcase
        end
        err_d = (state_q == ST_IDLE && frame_rise) ? 4'b0000 : (err_q | err_set);
    end

    maple_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push_q),
        .wr_data_i (asm_q),
        .pop_i     (bus.word_ready),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .rd_data_o (fifo_rd_data)
    );

    assign bus.hdr_valid  = hdr_valid_q;
    assign bus.hdr_cmd    = hdr_q.cmd;
    assign bus.hdr_dst    = hdr_q.dst;
    assign bus.hdr_src    = hdr_q.src;
    assign bus.hdr_len    = hdr_q.len;
    assign bus.word_valid = ~fifo_empty;
    assign bus.word_data  = fifo_rd_data;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.pkt_error  = err_q;
endmodule

// File: tb/tb_maple_packet_parser.sv
// Directed packet vectors plus reset and full-FIFO corner sequences for maple_packet_parser.
module tb_maple_packet_parser;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    maple_pkt_if bus();

    maple_packet_parser #(.FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    localparam int CRC_OK = 0, CRC_BAD = 1, CRC_NONE = 2;
`ifdef MAPLE_PKT_CRC_EN
    localparam logic [3:0] E_BADCRC = 4'b0100;
    localparam logic [3:0] E_NOCRC  = 4'b0001;
`else
    localparam logic [3:0] E_BADCRC = 4'b0010;
    localparam logic [3:0] E_NOCRC  = 4'b0000;
`endif

    typedef struct {
        logic [7:0]  len, src, dst, cmd;
        logic [7:0]  base, step;
        int          trunc;
        int          crc;
        int          extra;
        bit          coincide;
        logic [3:0]  exp_err;
        int          exp_words;
        logic [31:0] exp_w0;
    } vec_t;
    vec_t vecs[9];

    int checks = 0;
    int errors = 0;
    int hdr_cnt = 0;
    int done_cnt = 0;
    logic [31:0] got_q[$];

    always @(negedge clk) begin
        if (bus.word_valid && bus.word_ready) got_q.push_back(bus.word_data);
        if (bus.hdr_valid) hdr_cnt++;
        if (bus.pkt_done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.data_ready = 1'b1;
        bus.data = b;
        @(posedge clk); #1;
        bus.data_ready = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        bus.frame = 1'b1;
    endtask

    task automatic end_pkt(input bit cz, input logic [7:0] czb, input logic [3:0] exp_err, input string tag);
        int d0;
        @(posedge clk); #1;
        bus.frame = 1'b0;
        if (cz) begin
            bus.data_ready = 1'b1;
            bus.data = czb;
        end
        d0 = done_cnt;
        @(posedge clk); #1;
        bus.data_ready = 1'b0;
        chk({tag, "_done"}, 32'(bus.pkt_done), 32'd1);
        chk({tag, "_err"}, 32'(bus.pkt_error), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, 32'(bus.pkt_done), 32'd0);
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        bus.word_ready = 1'b1;
        while (bus.word_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        bus.word_ready = 1'b0;
        chk({tag, "_drain_timeout"}, 32'(k >= 40), 32'd0);
    endtask

    function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        logic [7:0] tx[$];
        logic [7:0] pay[$];
        logic [7:0] x;
        int g0, h0, nsend, npay, nw, ng;
        string tag;
        v = vecs[i];
        tag = $sformatf("v%0d", i);
        tx.push_back(v.len); tx.push_back(v.src); tx.push_back(v.dst); tx.push_back(v.cmd);
        for (int k = 0; k < 4 * int'(v.len); k++) pay.push_back(8'(v.base + 8'(k) * v.step));
        foreach (pay[k]) tx.push_back(pay[k]);
        x = 8'h00;
        foreach (tx[k]) x = x ^ tx[k];
`ifdef MAPLE_PKT_CRC_EN
        if (v.crc == CRC_OK) tx.push_back(x);
`endif
        if (v.crc == CRC_BAD) tx.push_back(8'hFF);
        for (int k = 0; k < v.extra; k++) tx.push_back(8'h5A);
        nsend = (v.trunc >= 0) ? v.trunc : tx.size();
        npay = (v.trunc >= 0) ? ((nsend > 4) ? nsend - 4 : 0) : pay.size();
        nw = npay / 4;
        if (nw > 8) nw = 8;
        g0 = got_q.size();
        h0 = hdr_cnt;
        start_frame();
        for (int k = 0; k < nsend; k++) begin
            send_byte(tx[k]);
            if (k == 3) begin
                chk({tag, "_hdr_valid"}, 32'(bus.hdr_valid), 32'd1);
                chk({tag, "_hdr"}, {bus.hdr_cmd, bus.hdr_dst, bus.hdr_src, bus.hdr_len},
                    {v.cmd, v.dst, v.src, v.len});
            end
        end
        end_pkt(v.coincide, v.coincide ? tx[nsend] : 8'h00, v.exp_err, tag);
        chk({tag, "_hdr_pulses"}, 32'(hdr_cnt - h0), 32'd1);
        drain(tag);
        ng = got_q.size() - g0;
        chk({tag, "_words"}, 32'(ng), 32'(v.exp_words));
        if (v.exp_words > 0 && ng > 0) chk({tag, "_w0"}, got_q[g0], v.exp_w0);
        for (int w = 0; w < nw && w < ng; w++)
            chk($sformatf("%s_w%0d_model", tag, w), got_q[g0 + w],
                pack(pay[4*w], pay[4*w+1], pay[4*w+2], pay[4*w+3]));
        $display("pkt %s len=%0d sent=%0d err=%b words=%0d", tag, v.len, nsend, bus.pkt_error, ng);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tx[$];
        logic [7:0] x;
        int g0, d0;

        vecs[0] = '{8'h00, 8'h00, 8'h20, 8'h01, 8'h00, 8'h00, -1, CRC_OK,   0, 1'b0, 4'b0000, 0, 32'h0};
        vecs[1] = '{8'h02, 8'h00, 8'h20, 8'h01, 8'h11, 8'h11, -1, CRC_OK,   0, 1'b0, 4'b0000, 2, 32'h44332211};
        vecs[2] = '{8'h02, 8'h00, 8'h20, 8'h01, 8'h11, 8'h11, -1, CRC_BAD,  0, 1'b0, E_BADCRC, 2, 32'h44332211};
        vecs[3] = '{8'h02, 8'h00, 8'h20, 8'h01, 8'h11, 8'h11,  6, CRC_OK,   0, 1'b0, 4'b0001, 0, 32'h0};
        vecs[4] = '{8'h02, 8'h05, 8'h06, 8'h07, 8'h11, 8'h11,  7, CRC_OK,   0, 1'b1, 4'b0001, 0, 32'h0};
        vecs[5] = '{8'h0A, 8'h01, 8'h02, 8'h03, 8'h01, 8'h01, -1, CRC_OK,   0, 1'b0, 4'b1000, 8, 32'h04030201};
        vecs[6] = '{8'h01, 8'h09, 8'h0A, 8'h0B, 8'hA0, 8'h01, -1, CRC_NONE, 0, 1'b0, E_NOCRC, 1, 32'hA3A2A1A0};
        vecs[7] = '{8'h01, 8'h0C, 8'h0D, 8'h0E, 8'hB0, 8'h01, -1, CRC_OK,   1, 1'b0, 4'b0010, 1, 32'hB3B2B1B0};
        vecs[8] = '{8'h02, 8'h0F, 8'h10, 8'h11, 8'h10, 8'h01,  8, CRC_OK,   0, 1'b0, 4'b0001, 1, 32'h13121110};

        bus.frame = 1'b0;
        bus.data_ready = 1'b0;
        bus.data = 8'h00;
        bus.word_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hdr_valid", 32'(bus.hdr_valid), 32'd0);
        chk("rst_hdr_fields", {bus.hdr_cmd, bus.hdr_dst, bus.hdr_src, bus.hdr_len}, 32'd0);
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_word_data", bus.word_data, 32'd0);
        chk("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
        chk("rst_pkt_error", 32'(bus.pkt_error), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
            repeat (2) @(posedge clk);
        end

        // Push into a full FIFO in the same cycle as a pop: both must take effect.
        g0 = got_q.size();
        tx.delete();
        tx.push_back(8'h09); tx.push_back(8'h21); tx.push_back(8'h22); tx.push_back(8'h23);
        for (int k = 0; k < 36; k++) tx.push_back(8'(8'h40 + k));
        x = 8'h00;
        foreach (tx[k]) x = x ^ tx[k];
        start_frame();
        foreach (tx[k]) begin
            send_byte(tx[k]);
            if (k == 39) begin
                bus.word_ready = 1'b1;
                @(posedge clk); #1;
                bus.word_ready = 1'b0;
            end
        end
`ifdef MAPLE_PKT_CRC_EN
        send_byte(x);
`endif
        end_pkt(1'b0, 8'h00, 4'b0000, "fullpop");
        drain("fullpop");
        chk("fullpop_words", 32'(got_q.size() - g0), 32'd9);
        for (int w = 0; w < 9 && g0 + w < got_q.size(); w++)
            chk($sformatf("fullpop_w%0d", w), got_q[g0 + w],
                pack(8'(8'h40 + 4*w), 8'(8'h41 + 4*w), 8'(8'h42 + 4*w), 8'(8'h43 + 4*w)));
        $display("pkt fullpop len=9 words=%0d err=%b", got_q.size() - g0, bus.pkt_error);

        // Reset mid-payload with one word already buffered.
        start_frame();
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        for (int k = 0; k < 5; k++) send_byte(8'(8'h70 + k));
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_pre_word_valid", 32'(bus.word_valid), 32'd1);
        reset = 1'b0;
        bus.frame = 1'b0;
        d0 = done_cnt;
        @(posedge clk); #1;
        chk("midrst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("midrst_word_data", bus.word_data, 32'd0);
        chk("midrst_hdr_fields", {bus.hdr_cmd, bus.hdr_dst, bus.hdr_src, bus.hdr_len}, 32'd0);
        chk("midrst_pkt_error", 32'(bus.pkt_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        g0 = got_q.size();
        start_frame();
        send_byte(8'h01); send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        chk("lat_word_valid_early", 32'(bus.word_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_word_valid", 32'(bus.word_valid), 32'd1);
        chk("lat_word_data", bus.word_data, 32'hD4C3B2A1);
`ifdef MAPLE_PKT_CRC_EN
        send_byte(8'h01 ^ 8'h31 ^ 8'h32 ^ 8'h33 ^ 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
`endif
        end_pkt(1'b0, 8'h00, 4'b0000, "postrst");
        drain("postrst");
        chk("postrst_words", 32'(got_q.size() - g0), 32'd1);
        if (got_q.size() > g0) chk("postrst_w0", got_q[g0], 32'hD4C3B2A1);
        $display("pkt postrst len=1 words=%0d err=%b", got_q.size() - g0, bus.pkt_error);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
